instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have these ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request carries instruction fields
- in_ready_o  out  1  block can accept a request
- fmt  in  4  class: 0 LOAD, 1 IMM, 2 AUIPC, 3 STORE, 4 OP, 5 LUI, 6 BRANCH, 7 JALR, 8 JAL
- funct3  in  3  funct3 field
- alt  in  1  selects SUB/SRA/SRAI (funct7[5]=1)
- mext  in  1  selects M-extension, funct7=0000001
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  sign-extended immediate (byte offset for BRANCH/JAL; upper 20 bits in imm[31:12] for LUI/AUIPC)
- instr_o  out  32  encoded word at FIFO head
- out_valid_o  out  1  instr_o is valid
- out_ready  in  1  consumer takes instr_o
- err_o  out  1  one-cycle pulse: illegal request dropped
- count_o  out  3  FIFO occupancy, 0..4

Function
REQ-002 A request SHALL be accepted on a rising clk edge when in_valid=1 and in_ready_o=1.
REQ-003 in_ready_o SHALL equal (count_o<4), independent of out_ready.
REQ-004 Opcodes SHALL be: LOAD 0000011, IMM 0010011, AUIPC 0010111, STORE 0100011, OP 0110011, LUI 0110111, BRANCH 1100011, JALR 1100111, JAL 1101111.
REQ-005 The block SHALL pack fields in standard RV32 R/I/S/B/U/J layout: R for OP; I for LOAD, IMM, JALR; S for STORE; B for BRANCH; U for LUI, AUIPC; J for JAL.
REQ-006 For OP, funct7 SHALL be 0000001 if mext=1, else {1'b0,alt,5'b0}.
REQ-007 For IMM with funct3=001 or 101, bits[31:25] SHALL be {1'b0,alt,5'b0} and bits[24:20]=imm[4:0]; other IMM funct3 values SHALL use imm[11:0].
REQ-008 For JAL, LUI and AUIPC, funct3 SHALL be ignored; for LOAD, STORE and BRANCH, funct3 SHALL be copied unchecked; for JALR, bits[14:12] SHALL be 000.
REQ-009 A request SHALL be illegal, and SHALL not be enqueued, if any of the following holds: fmt>8; mext=1 with fmt≠4; BRANCH/JAL with imm[0]=1; JALR with funct3≠000.
REQ-010 An accepted illegal request SHALL pulse err_o high for exactly the cycle after acceptance.
REQ-011 Legal requests SHALL be written into a 4-entry FIFO; the entry becomes visible on instr_o/out_valid_o in the cycle after acceptance (latency 1).
REQ-012 out_valid_o SHALL equal (count_o≠0), and instr_o SHALL present the oldest entry.
REQ-013 A pop SHALL occur on an edge with out_valid_o=1 and out_ready=1.
REQ-014 On simultaneous push and pop, count_o SHALL be unchanged and order SHALL be preserved, including at count 4 when no push can occur.
REQ-015 Read and write pointers SHALL be 2-bit and SHALL wrap modulo 4.
REQ-016 When count_o=0, instr_o SHALL be 32'h00000013 (NOP).

Reset
REQ-017 While rst_n=0: count_o=0, pointers=0, out_valid_o=0, err_o=0, in_ready_o=1, instr_o=32'h00000013.
REQ-018 Reset SHALL take effect asynchronously; FIFO contents are discarded.
REQ-019 Reset release SHALL be synchronous to clk, and the first acceptance is possible on the first rising edge after release.

Configuration
REQ-020 Macro ENC_M_EXT_EN SHALL control M-extension support.
REQ-021 With ENC_M_EXT_EN defined, REQ-006 SHALL apply in full.
REQ-022 Without ENC_M_EXT_EN, any request with mext=1 SHALL be illegal per REQ-009/REQ-010.

Verification
REQ-023 fmt=1, funct3=000, rd=1, rs1=0, imm=5 -> instr_o=0x00500093 one cycle later.
REQ-024 fmt=4, funct3=000, alt=1, rd=3, rs1=1, rs2=2 -> 0x402081B3; fmt=3, funct3=010, rs1=1, rs2=2, imm=4 -> 0x0020A223.
REQ-025 fmt=8, rd=1, imm=8 -> 0x008000EF; fmt=6, imm=3 -> err_o pulses, count_o unchanged.
REQ-026 out_ready=0, five back-to-back legal requests -> in_ready_o=0 after the fourth, count_o=4; then out_ready=1 -> words emerge in order, count_o decrements to 0.
REQ-027 fmt=4, mext=1, funct3=000, rd=5, rs1=6, rs2=7 -> 0x027302B3 with ENC_M_EXT_EN, err_o pulse without it.
REQ-028 rst_n low with count_o=3 -> count_o=0, out_valid_o=0, instr_o=0x00000013 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs decoded fields into 32-bit words and queues legal ones in a 4-entry FIFO.
// Optional M-extension encoding is enabled by defining ENC_M_EXT_EN; otherwise mext=1 requests are illegal.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready_o,
  input  logic [3:0]  fmt,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic        mext,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr_o,
  output logic        out_valid_o,
  input  logic        out_ready,
  output logic        err_o,
  output logic [2:0]  count_o
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  function automatic logic [31:0] encode(
    input logic [3:0]  f,
    input logic [2:0]  f3,
    input logic        a,
    input logic        m,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [31:0] im
  );
    logic [6:0] f7;
    f7 = m ? 7'b000_0001 : {1'b0, a, 5'b0_0000};
    case (f)
      4'd0: encode = {im[11:0], s1, f3, d, 7'b000_0011};
      4'd1: begin
        // Shift-immediates carry shamt in [24:20] and the arithmetic selector in [30]
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          encode = {1'b0, a, 5'b0_0000, im[4:0], s1, f3, d, 7'b001_0011};
        end else begin
          encode = {im[11:0], s1, f3, d, 7'b001_0011};
        end
      end
      4'd2: encode = {im[31:12], d, 7'b001_0111};
      4'd3: encode = {im[11:5], s2, s1, f3, im[4:0], 7'b010_0011};
      4'd4: encode = {f7, s2, s1, f3, d, 7'b011_0011};
      4'd5: encode = {im[31:12], d, 7'b011_0111};
      4'd6: encode = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b110_0011};
      4'd7: encode = {im[11:0], s1, 3'b000, d, 7'b110_0111};
      4'd8: encode = {im[20], im[10:1], im[11], im[19:12], d, 7'b110_1111};
      default: encode = NOP_WORD;
    endcase
  endfunction

  logic [31:0] mem_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        err_q, err_d;
  logic        illegal_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic [31:0] word_s;

  // Legality check and handshake decode
  always_comb begin
    illegal_s = 1'b0;
    if (fmt > 4'd8) begin
      illegal_s = 1'b1;
    end else if (mext && (fmt != 4'd4)) begin
      illegal_s = 1'b1;
    end else if (((fmt == 4'd6) || (fmt == 4'd8)) && imm[0]) begin
      illegal_s = 1'b1;
    end else if ((fmt == 4'd7) && (funct3 != 3'b000)) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = 1'b0;
    end
`ifndef ENC_M_EXT_EN
    if (mext) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = illegal_s;
    end
`endif
    accept_s = in_valid && in_ready_o;
    push_s   = accept_s && !illegal_s;
    pop_s    = out_valid_o && out_ready;
    word_s   = encode(fmt, funct3, alt, mext, rd, rs1, rs2, imm);
  end

  // Pointer, occupancy and error-pulse next state
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + 2'd1 : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    err_d = accept_s && illegal_s;
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= word_s;
    end
  end

  assign count_o     = count_q;
  assign in_ready_o  = (count_q < 3'd4);
  assign out_valid_o = (count_q != 3'd0);
  assign err_o       = err_q;
  assign instr_o     = (count_q == 3'd0) ? NOP_WORD : mem_q[rd_ptr_q];

endmodule
